key_conditioner: RTL and testbench

//   Conditions the four raw push-button direction inputs before they reach the character movement logic.
//   - 2-FF synchronizer and debounce filter per key.
//   - Clean active-low levels out, plus one-cycle step pulses with typematic auto-repeat.
//   - Sits between the board key pins and the character/position block.

---
 rtl/key_conditioner.sv | 151 +++++++++++++++
 tb/tb_key_conditioner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Conditions four raw active-low direction buttons: synchronize, debounce, and
// turn held keys into one-cycle step pulses with typematic auto-repeat.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 20000000,
    parameter int unsigned REPEAT_RATE     = 4000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic enable,
    input  logic key_up_raw,
    input  logic key_down_raw,
    input  logic key_left_raw,
    input  logic key_right_raw,
    output logic keyUp,
    output logic keyDown,
    output logic keyLeft,
    output logic keyRight,
    output logic step_up,
    output logic step_down,
    output logic step_left,
    output logic step_right,
    output logic any_pressed
);

    localparam int unsigned NKEYS   = 4;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RP_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Key index order: 0 up, 1 down, 2 left, 3 right.
    logic [NKEYS-1:0] raw;
    logic [NKEYS-1:0] sync1_q, sync1_d;
    logic [NKEYS-1:0] sync2_q, sync2_d;
    logic [NKEYS-1:0] clean_q, clean_d;
    logic [NKEYS-1:0] step_q, step_d;
    logic [NKEYS-1:0] pulse;
    logic [NKEYS-1:0] opp_clean;
    logic             any_pressed_q, any_pressed_d;

    logic [DB_W-1:0]  db_cnt_q [NKEYS];
    logic [DB_W-1:0]  db_cnt_d [NKEYS];
    logic [RP_W-1:0]  rp_cnt_q [NKEYS];
    logic [RP_W-1:0]  rp_cnt_d [NKEYS];
    rpt_state_e       state_q  [NKEYS];
    rpt_state_e       state_d  [NKEYS];

    assign raw = {key_right_raw, key_left_raw, key_down_raw, key_up_raw};

    // Synchronizer and debounce: accept a new level only after a full run of mismatches.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        for (int k = 0; k < NKEYS; k++) begin
            db_cnt_d[k] = '0;
            if (sync2_q[k] != clean_q[k]) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    clean_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    // Repeat FSMs run on the registered clean level, so the first pulse lands one cycle after it falls.
    always_comb begin
        pulse = '0;
        for (int k = 0; k < NKEYS; k++) begin
            state_d[k]  = state_q[k];
            rp_cnt_d[k] = '0;
            if (clean_q[k] || !enable) begin
                state_d[k] = IDLE;
            end else begin
                case (state_q[k])
                    IDLE: begin
                        pulse[k]   = 1'b1;
                        state_d[k] = DELAY;
                    end
                    DELAY: begin
                        if (rp_cnt_q[k] == RP_W'(REPEAT_DELAY - 1)) begin
                            pulse[k]   = 1'b1;
                            state_d[k] = REPEAT;
                        end else begin
                            rp_cnt_d[k] = rp_cnt_q[k] + RP_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (rp_cnt_q[k] == RP_W'(REPEAT_RATE - 1)) begin
                            pulse[k] = 1'b1;
                        end else begin
                            rp_cnt_d[k] = rp_cnt_q[k] + RP_W'(1);
                        end
                    end
                    default: state_d[k] = IDLE;
                endcase
            end
        end
    end

    // Opposing-key mask uses the level visible alongside the pulse; FSM timing is untouched.
    always_comb begin
        opp_clean     = {clean_d[2], clean_d[3], clean_d[0], clean_d[1]};
        step_d        = pulse & opp_clean;
        any_pressed_d = ~&clean_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            clean_q       <= '1;
            step_q        <= '0;
            any_pressed_q <= 1'b0;
            for (int k = 0; k < NKEYS; k++) begin
                db_cnt_q[k] <= '0;
                rp_cnt_q[k] <= '0;
                state_q[k]  <= IDLE;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            clean_q       <= clean_d;
            step_q        <= step_d;
            any_pressed_q <= any_pressed_d;
            for (int k = 0; k < NKEYS; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
                rp_cnt_q[k] <= rp_cnt_d[k];
                state_q[k]  <= state_d[k];
            end
        end
    end

    assign keyUp       = clean_q[0];
    assign keyDown     = clean_q[1];
    assign keyLeft     = clean_q[2];
    assign keyRight    = clean_q[3];
    assign step_up     = step_q[0];
    assign step_down   = step_q[1];
    assign step_left   = step_q[2];
    assign step_right  = step_q[3];
    assign any_pressed = any_pressed_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat parameters;
// expected levels and pulse edges are hand-derived per scenario.
module tb_key_conditioner;

    logic CLOCK_50 = 1'b0;
    logic reset, enable;
    logic key_up_raw, key_down_raw, key_left_raw, key_right_raw;
    logic keyUp, keyDown, keyLeft, keyRight;
    logic step_up, step_down, step_left, step_right, any_pressed;

    int n_cmp = 0;
    int n_err = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .enable       (enable),
        .key_up_raw   (key_up_raw),
        .key_down_raw (key_down_raw),
        .key_left_raw (key_left_raw),
        .key_right_raw(key_right_raw),
        .keyUp        (keyUp),
        .keyDown      (keyDown),
        .keyLeft      (keyLeft),
        .keyRight     (keyRight),
        .step_up      (step_up),
        .step_down    (step_down),
        .step_left    (step_left),
        .step_right   (step_right),
        .any_pressed  (any_pressed)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input int e, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s edge %0d: got %b expected %b", tag, e, obs, exp);
        end
    endtask

    // keys/steps bit order: 0 up, 1 down, 2 left, 3 right.
    task automatic chk_all(input string tc, input int e, input logic [3:0] k, input logic [3:0] s);
        chk({tc, ".keyUp"},      e, keyUp,      k[0]);
        chk({tc, ".keyDown"},    e, keyDown,    k[1]);
        chk({tc, ".keyLeft"},    e, keyLeft,    k[2]);
        chk({tc, ".keyRight"},   e, keyRight,   k[3]);
        chk({tc, ".step_up"},    e, step_up,    s[0]);
        chk({tc, ".step_down"},  e, step_down,  s[1]);
        chk({tc, ".step_left"},  e, step_left,  s[2]);
        chk({tc, ".step_right"}, e, step_right, s[3]);
        chk({tc, ".any_pressed"}, e, any_pressed, ~&k);
    endtask

    initial begin
        logic [3:0] ek, es;
        reset = 1'b0; enable = 1'b1;
        key_up_raw = 1'b1; key_down_raw = 1'b1; key_left_raw = 1'b1; key_right_raw = 1'b1;

        // Reset state
        for (int i = 0; i < 3; i++) tick();
        chk_all("rst", 0, 4'hF, 4'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk_all("idle", 0, 4'hF, 4'h0);

        // 1: up pressed and held; debounce latency, first pulse, delay, repeats
        for (int e = 0; e <= 22; e++) begin
            key_up_raw = 1'b0;
            tick();
            ek = 4'hF; es = 4'h0;
            ek[0] = !(e >= 5);
            es[0] = e inside {6, 16, 19, 22};
            chk_all("t1", e, ek, es);
        end
        key_up_raw = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk_all("t1rel", 34, 4'hF, 4'h0);

        // 2: left glitch of 3 cycles is rejected
        for (int e = 0; e <= 11; e++) begin
            key_left_raw = (e < 3) ? 1'b0 : 1'b1;
            tick();
            chk_all("t2", e, 4'hF, 4'h0);
        end

        // 3: right held past first repeat, then released
        for (int e = 0; e <= 30; e++) begin
            key_right_raw = (e < 18) ? 1'b0 : 1'b1;
            tick();
            ek = 4'hF; es = 4'h0;
            ek[3] = !(e >= 5 && e < 23);
            es[3] = e inside {6, 16, 19, 22};
            chk_all("t3", e, ek, es);
        end

        // 4: up held, down pressed and released; opposing masking and cadence
        for (int e = 0; e <= 52; e++) begin
            key_up_raw   = (e < 42) ? 1'b0 : 1'b1;
            key_down_raw = (e >= 20 && e < 30) ? 1'b0 : 1'b1;
            tick();
            ek = 4'hF; es = 4'h0;
            ek[0] = !(e >= 5 && e < 47);
            ek[1] = !(e >= 25 && e < 35);
            es[0] = e inside {6, 16, 19, 22, 37, 40, 43, 46};
            chk_all("t4", e, ek, es);
        end

        // 5: enable dropped while down held, then restored
        for (int e = 0; e <= 28; e++) begin
            key_down_raw = 1'b0;
            enable = (e >= 8 && e < 14) ? 1'b0 : 1'b1;
            tick();
            ek = 4'hF; es = 4'h0;
            ek[1] = !(e >= 5);
            es[1] = e inside {6, 14, 24, 27};
            chk_all("t5", e, ek, es);
        end
        key_down_raw = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk_all("t5rel", 40, 4'hF, 4'h0);

        // 6: reset mid-repeat with right held, then full re-debounce
        for (int e = 0; e <= 20; e++) begin
            key_right_raw = 1'b0;
            tick();
            ek = 4'hF; es = 4'h0;
            ek[3] = !(e >= 5);
            es[3] = e inside {6, 16, 19};
            chk_all("t6", e, ek, es);
        end
        for (int e = 21; e <= 32; e++) begin
            reset = (e < 23) ? 1'b0 : 1'b1;
            tick();
            ek = 4'hF; es = 4'h0;
            if (e >= 23) begin
                ek[3] = !((e - 23) >= 5);
                es[3] = ((e - 23) == 6);
            end
            chk_all("t6rst", e, ek, es);
        end
        key_right_raw = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk_all("t6rel", 44, 4'hF, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
